// File: rtl/fifo_rd_stream.sv
// Read-side FIFO consumer: pops the FIFO head into a 2-entry skid buffer and
// presents it as a valid/ready stream, with synchronous flush and a delivered-word counter.
module fifo_rd_stream #(
    parameter int DSIZE = 8,
    parameter int CNTW  = 16
) (
    input  logic             rclk,
    input  logic             rrst_n,
    input  logic [DSIZE-1:0] rdata,
    input  logic             rempty,
    output logic             rinc,
    input  logic             en,
    input  logic             flush,
    output logic [DSIZE-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNTW-1:0]  rd_count,
    output logic             idle
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [DSIZE-1:0] out_q, out_d;
    logic [DSIZE-1:0] skid_q, skid_d;
    logic [CNTW-1:0]  count_q, count_d;
    logic             pop;
    logic             take;

    // Pop decision uses only registered state and FIFO flags, never out_ready;
    // gating with rrst_n keeps the FIFO pointer still while reset is held.
    assign pop       = rrst_n & en & ~rempty & ~flush & (state_q != ST_TWO);
    assign rinc      = pop;
    assign out_valid = (state_q != ST_EMPTY);
    assign out_data  = out_q;
    assign take      = out_valid & out_ready;
    assign rd_count  = count_q;
    assign idle      = (state_q == ST_EMPTY) & rempty;

    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        skid_d  = skid_q;
        count_d = take ? count_q + CNTW'(1) : count_q;

        if (flush) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (pop) begin
                        state_d = ST_ONE;
                        out_d   = rdata;
                    end
                end
                ST_ONE: begin
                    if (pop && take) begin
                        out_d = rdata;
                    end else if (pop) begin
                        state_d = ST_TWO;
                        skid_d  = rdata;
                    end else if (take) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    if (take) begin
                        state_d = ST_ONE;
                        out_d   = skid_q;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            state_q <= ST_EMPTY;
            out_q   <= '0;
            skid_q  <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            skid_q  <= skid_d;
            count_q <= count_d;
        end
    end

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Directed bench for fifo_rd_stream: a small FIFO model feeds two instances
// (16-bit and 4-bit counters) from the same stimulus.
module tb_fifo_rd_stream;

    logic       clk = 1'b0;
    logic       rrst_n;
    logic [7:0] rdata;
    logic       rempty;
    logic       rinc, rinc4;
    logic       en, flush, out_ready;
    logic [7:0] out_data, out_data4;
    logic       out_valid, out_valid4;
    logic [15:0] rd_count;
    logic [3:0]  rd_count4;
    logic       idle, idle4;

    int checks = 0;
    int errors = 0;

    logic [7:0] mem [0:63];
    int wptr = 0;
    int rptr = 0;
    logic [7:0] got [$];

    always #5 clk = ~clk;

    assign rdata  = mem[rptr[5:0]];
    assign rempty = (rptr == wptr);

    always @(posedge clk) begin
        if (rinc) rptr <= rptr + 1;
        if (rrst_n && out_valid && out_ready) got.push_back(out_data);
    end

    fifo_rd_stream #(.DSIZE(8), .CNTW(16)) dut (
        .rclk(clk), .rrst_n(rrst_n), .rdata(rdata), .rempty(rempty), .rinc(rinc),
        .en(en), .flush(flush), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .rd_count(rd_count), .idle(idle)
    );

    fifo_rd_stream #(.DSIZE(8), .CNTW(4)) dut4 (
        .rclk(clk), .rrst_n(rrst_n), .rdata(rdata), .rempty(rempty), .rinc(rinc4),
        .en(en), .flush(flush), .out_data(out_data4), .out_valid(out_valid4),
        .out_ready(out_ready), .rd_count(rd_count4), .idle(idle4)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, obs);
        end
    endtask

    task automatic push(input logic [7:0] v);
        mem[wptr[5:0]] = v;
        wptr = wptr + 1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rrst_n = 1'b0; en = 1'b1; flush = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 8; i++) push(8'(8'h11 + i));
        tick(); tick();

        // reset with a non-empty FIFO
        check("rst_rinc", 32'(rinc), 32'd0);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_count", 32'(rd_count), 32'd0);
        check("rst_data", 32'(out_data), 32'd0);
        check("rst_idle", 32'(idle), 32'd0);

        rrst_n = 1'b1;
        #1;
        check("rel_rinc", 32'(rinc), 32'd1);

        // streaming 0x11..0x18 on consecutive cycles
        for (int k = 1; k <= 8; k++) begin
            tick();
            check($sformatf("stream_valid%0d", k), 32'(out_valid), 32'd1);
            check($sformatf("stream_data%0d", k), 32'(out_data), 32'(8'h10 + k));
        end
        tick();
        check("stream_count", 32'(rd_count), 32'd8);
        check("stream_idle", 32'(idle), 32'd1);
        check("stream_valid_end", 32'(out_valid), 32'd0);

        // backpressure: two pops then stall
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) push(8'(8'hA0 + i));
        #1;
        check("bp_rinc0", 32'(rinc), 32'd1);
        tick();
        check("bp_rinc1", 32'(rinc), 32'd1);
        tick();
        check("bp_rinc2", 32'(rinc), 32'd0);
        check("bp_data2", 32'(out_data), 32'hA0);
        tick(); tick();
        check("bp_hold_rinc", 32'(rinc), 32'd0);
        check("bp_hold_data", 32'(out_data), 32'hA0);
        check("bp_hold_valid", 32'(out_valid), 32'd1);
        check("bp_popped", 32'(rptr - 8), 32'd2);
        got.delete();
        out_ready = 1'b1;
        for (int i = 0; i < 20 && !idle; i++) tick();
        check("bp_idle", 32'(idle), 32'd1);
        check("bp_n", 32'(got.size()), 32'd4);
        for (int i = 0; i < 4; i++)
            check($sformatf("bp_word%0d", i), 32'(got.size() > i ? got[i] : 8'h00), 32'(8'hA0 + i));
        check("bp_count", 32'(rd_count), 32'd12);

        // flush while holding 0x55,0x66 with 0x77 still in the FIFO
        out_ready = 1'b0;
        push(8'h55); push(8'h66); push(8'h77);
        tick(); tick();
        check("fl_data", 32'(out_data), 32'h55);
        flush = 1'b1;
        #1;
        check("fl_rinc", 32'(rinc), 32'd0);
        tick();
        flush = 1'b0;
        check("fl_valid", 32'(out_valid), 32'd0);
        check("fl_count", 32'(rd_count), 32'd12);
        #1;
        check("fl_rinc_after", 32'(rinc), 32'd1);
        out_ready = 1'b1;
        tick();
        check("fl_next", 32'(out_data), 32'h77);
        tick();
        check("fl_count2", 32'(rd_count), 32'd13);

        // enable gating with ONE holding 0x3C
        out_ready = 1'b0;
        push(8'h3C);
        tick();
        en = 1'b0;
        push(8'h4D); push(8'h5E);
        #1;
        check("en_rinc0", 32'(rinc), 32'd0);
        tick(); tick();
        check("en_rinc1", 32'(rinc), 32'd0);
        check("en_data", 32'(out_data), 32'h3C);
        out_ready = 1'b1;
        tick();
        check("en_drain_count", 32'(rd_count), 32'd14);
        check("en_drain_valid", 32'(out_valid), 32'd0);
        tick();
        check("en_still_valid", 32'(out_valid), 32'd0);
        check("en_still_rinc", 32'(rinc), 32'd0);
        check("en_idle", 32'(idle), 32'd0);
        en = 1'b1;
        #1;
        check("en_resume_rinc", 32'(rinc), 32'd1);
        tick();
        check("en_word1", 32'(out_data), 32'h4D);
        tick();
        check("en_word2", 32'(out_data), 32'h5E);
        tick();
        check("en_count", 32'(rd_count), 32'd16);
        check("wrap_zero", 32'(rd_count4), 32'd0);

        // 17th word wraps the 4-bit counter
        push(8'h99);
        tick();
        check("wrap_data", 32'(out_data), 32'h99);
        tick();
        check("wrap_count16", 32'(rd_count), 32'd17);
        check("wrap_count4", 32'(rd_count4), 32'd1);

        // take coinciding with flush is still counted; FIFO word survives
        push(8'hAA); push(8'hBB);
        tick();
        check("tf_data", 32'(out_data), 32'hAA);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("tf_count", 32'(rd_count), 32'd18);
        check("tf_valid", 32'(out_valid), 32'd0);
        tick();
        check("tf_next", 32'(out_data), 32'hBB);
        tick();
        check("tf_count2", 32'(rd_count4), 32'd3);

        // asynchronous reset mid-operation drops buffered words
        out_ready = 1'b0;
        push(8'hC1); push(8'hC2);
        tick(); tick();
        #2 rrst_n = 1'b0;
        #1;
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_rinc", 32'(rinc), 32'd0);
        check("mid_rst_count", 32'(rd_count), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
